// File: rtl/ddr3_dfi_responder.sv
// DFI-side DDR3 x16 device/PHY emulator: decodes DFI commands, tracks open rows,
// stores masked write beats and returns read beats after a fixed latency.

module ddr3_dfi_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  // DEPTH must be a power of two >= 2 so the pointers wrap naturally.
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  slots [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  assign dout  = slots[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module ddr3_dfi_responder #(
  parameter int MEM_AW         = 12,
  parameter int RD_LATENCY     = 4,
  parameter int ROW_W          = 15,
  parameter int CMD_FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [14:0] dfi_address_i,
  input  logic [2:0]  dfi_bank_i,
  input  logic        dfi_cs_n_i,
  input  logic        dfi_ras_n_i,
  input  logic        dfi_cas_n_i,
  input  logic        dfi_we_n_i,
  input  logic        dfi_cke_i,
  input  logic        dfi_reset_n_i,
  input  logic        dfi_odt_i,
  input  logic [31:0] dfi_wrdata_i,
  input  logic        dfi_wrdata_en_i,
  input  logic [3:0]  dfi_wrdata_mask_i,
  input  logic        dfi_rddata_en_i,
  output logic [31:0] dfi_rddata_o,
  output logic        dfi_rddata_valid_o,
  output logic [1:0]  dfi_rddata_dnv_o,
  output logic [7:0]  err_o
);
  localparam int FULL_W = 3 + ROW_W + 7 + 2;

  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_NOP = 3'b111
  } cmd_e;

  logic [2:0]        cmd_bits;
  logic              cmd_valid;
  logic              is_act, is_rd, is_wr, is_pre, is_ref;
  logic              a10;
  logic              sel_open;
  logic              any_open;
  logic [7:0]        open_q;
  logic [ROW_W-1:0]  row_q [8];
  logic [FULL_W-1:0] cmd_addr;
  logic [MEM_AW-1:0] cmd_base;

  logic [31:0]       mem [2**MEM_AW];

  logic              wr_empty, wr_full, wr_push, wr_pop, wr_beat_ok;
  logic [1:0]        wr_beat;
  logic [MEM_AW-1:0] wr_base, wr_addr;
  logic              rd_empty, rd_full, rd_push, rd_pop, rd_beat_ok;
  logic [1:0]        rd_beat;
  logic [MEM_AW-1:0] rd_base, rd_addr;

  logic [RD_LATENCY-1:0] vld_pipe;
  logic [31:0]           dat_pipe [RD_LATENCY];
  logic [5:0]            err_q;
  logic                  unused_ok;

  assign cmd_bits  = {dfi_ras_n_i, dfi_cas_n_i, dfi_we_n_i};
  assign cmd_valid = dfi_cke_i && !dfi_cs_n_i;
  assign is_act    = cmd_valid && (cmd_bits == CMD_ACT);
  assign is_rd     = cmd_valid && (cmd_bits == CMD_RD);
  assign is_wr     = cmd_valid && (cmd_bits == CMD_WR);
  assign is_pre    = cmd_valid && (cmd_bits == CMD_PRE);
  assign is_ref    = cmd_valid && (cmd_bits == CMD_REF);
  assign a10       = dfi_address_i[10];
  assign sel_open  = open_q[dfi_bank_i];
  assign any_open  = |open_q;

  // Bursts are 4 beats, so the base address always has its two low bits clear.
  assign cmd_addr = {dfi_bank_i, row_q[dfi_bank_i], dfi_address_i[9:3], 2'b00};
  assign cmd_base = cmd_addr[MEM_AW-1:0];

  assign wr_beat_ok = dfi_wrdata_en_i && !wr_empty;
  assign wr_pop     = wr_beat_ok && (wr_beat == 2'd3);
  assign wr_push    = is_wr && sel_open && (!wr_full || wr_pop);
  assign wr_addr    = wr_base | MEM_AW'(wr_beat);

  assign rd_beat_ok = dfi_rddata_en_i && !rd_empty;
  assign rd_pop     = rd_beat_ok && (rd_beat == 2'd3);
  assign rd_push    = is_rd && sel_open && (!rd_full || rd_pop);
  assign rd_addr    = rd_base | MEM_AW'(rd_beat);

  ddr3_dfi_cmd_fifo #(.DEPTH(CMD_FIFO_DEPTH), .W(MEM_AW)) u_wr_fifo (
    .clk(clk_i), .rst(rst_i), .push(wr_push), .pop(wr_pop),
    .din(cmd_base), .dout(wr_base), .empty(wr_empty), .full(wr_full)
  );

  ddr3_dfi_cmd_fifo #(.DEPTH(CMD_FIFO_DEPTH), .W(MEM_AW)) u_rd_fifo (
    .clk(clk_i), .rst(rst_i), .push(rd_push), .pop(rd_pop),
    .din(cmd_base), .dout(rd_base), .empty(rd_empty), .full(rd_full)
  );

  // Auto-precharge closes the bank only after the command has used its row.
  always_ff @(posedge clk_i) begin
    if (rst_i || !dfi_reset_n_i) begin
      open_q <= '0;
    end else begin
      if (is_act) begin
        open_q[dfi_bank_i] <= 1'b1;
        row_q[dfi_bank_i]  <= dfi_address_i[ROW_W-1:0];
      end
      if (is_pre) begin
        if (a10) open_q <= '0;
        else     open_q[dfi_bank_i] <= 1'b0;
      end
      if ((is_rd || is_wr) && sel_open && a10) open_q[dfi_bank_i] <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_beat <= '0;
      rd_beat <= '0;
    end else begin
      if (wr_beat_ok) wr_beat <= wr_beat + 1'b1;
      if (rd_beat_ok) rd_beat <= rd_beat + 1'b1;
    end
  end

  // Backing store is never reset so data survives a controller reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_beat_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (!dfi_wrdata_mask_i[b]) mem[wr_addr][8*b +: 8] <= dfi_wrdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe <= '0;
      for (int i = 0; i < RD_LATENCY; i++) dat_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= dfi_rddata_en_i;
      dat_pipe[0] <= rd_beat_ok ? mem[rd_addr] : 32'h0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= '0;
    end else begin
      err_q <= err_q | {
        (is_wr && sel_open && wr_full && !wr_pop) || (is_rd && sel_open && rd_full && !rd_pop),
        is_ref && any_open,
        dfi_rddata_en_i && rd_empty,
        dfi_wrdata_en_i && wr_empty,
        (is_rd || is_wr) && !sel_open,
        is_act && sel_open
      };
    end
  end

  assign dfi_rddata_o       = dat_pipe[RD_LATENCY-1];
  assign dfi_rddata_valid_o = vld_pipe[RD_LATENCY-1];
  assign dfi_rddata_dnv_o   = 2'b00;
  assign err_o              = {2'b00, err_q};

  assign unused_ok = ^{dfi_odt_i, dfi_address_i, cmd_addr};
endmodule
